cic3_decimator: RTL



---
 rtl/cic3_decimator.sv | 85 ++++++++
 1 files changed

// File: rtl/cic3_decimator.sv
// Third-order CIC (sinc3) decimator: 1-bit delta-sigma stream in, one unsigned
// PCM word plus a single-cycle valid strobe out per 2**DECIM_LOG2 accepted bits.
module cic3_decimator #(
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sampleEn,
  input  logic                 dsmIn,
  output logic [OUT_WIDTH-1:0] dataOut,
  output logic                 dataValid
);

  localparam int ACC_WIDTH = 3*DECIM_LOG2 + 1;
  localparam int FULL_W    = 3*DECIM_LOG2;

  logic [ACC_WIDTH-1:0]  r_i1_p0, r_i2_p0, r_i3_p0;
  logic [DECIM_LOG2-1:0] r_cnt_p0;
  logic                  r_decim_tick_p1;
  logic [ACC_WIDTH-1:0]  r_d1_p1, r_d2_p1, r_d3_p1;
  logic [OUT_WIDTH-1:0]  r_data_p2;
  logic                  r_vld_p2;

  logic [ACC_WIDTH-1:0]  w_dsm_ext;
  logic                  w_frame_end;
  logic [ACC_WIDTH-1:0]  w_y1, w_y2, w_y3;

  // Only the exact full-scale sum (2**FULL_W) can set the top bit; clamp it so
  // an all-ones input maps to the maximum code instead of wrapping to zero.
  function automatic logic [OUT_WIDTH-1:0] sat_scale(input logic [ACC_WIDTH-1:0] v);
    logic [FULL_W-1:0] s;
    s = v[ACC_WIDTH-1] ? {FULL_W{1'b1}} : v[FULL_W-1:0];
    return s[FULL_W-1 -: OUT_WIDTH];
  endfunction

  assign w_dsm_ext   = {{(ACC_WIDTH-1){1'b0}}, dsmIn};
  assign w_frame_end = sampleEn && (r_cnt_p0 == {DECIM_LOG2{1'b1}});

  // Stage p0: integrators and decimation counter, advancing on accepted bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i1_p0         <= '0;
      r_i2_p0         <= '0;
      r_i3_p0         <= '0;
      r_cnt_p0        <= '0;
      r_decim_tick_p1 <= 1'b0;
    end else begin
      if (sampleEn) begin
        r_i1_p0  <= r_i1_p0 + w_dsm_ext;
        r_i2_p0  <= r_i2_p0 + r_i1_p0;
        r_i3_p0  <= r_i3_p0 + r_i2_p0;
        r_cnt_p0 <= r_cnt_p0 + 1'b1;
      end
      r_decim_tick_p1 <= w_frame_end;
    end
  end

  assign w_y1 = r_i3_p0 - r_d1_p1;
  assign w_y2 = w_y1 - r_d2_p1;
  assign w_y3 = w_y2 - r_d3_p1;

  // Stage p1/p2: comb delays and output register, updated once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d1_p1   <= '0;
      r_d2_p1   <= '0;
      r_d3_p1   <= '0;
      r_data_p2 <= '0;
      r_vld_p2  <= 1'b0;
    end else begin
      r_vld_p2 <= r_decim_tick_p1;
      if (r_decim_tick_p1) begin
        r_d1_p1   <= r_i3_p0;
        r_d2_p1   <= w_y1;
        r_d3_p1   <= w_y2;
        r_data_p2 <= sat_scale(w_y3);
      end
    end
  end

  assign dataOut   = r_data_p2;
  assign dataValid = r_vld_p2;

endmodule
